// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the gshare branch predictor.
// Holds the counter reset value, the saturating counter arithmetic, the PHT index hash
// and the GHR next-value selector.
package branch_pred_pkg;

    // Widest supported counter; narrower counters are zero-extended into this type.
    localparam int unsigned CTR_W_MAX = 4;
    typedef logic [CTR_W_MAX-1:0] ctr_t;

    // Source of the next speculative GHR value, in priority order (reset excluded).
    typedef enum logic [1:0] {
        GhrHold,
        GhrShift,
        GhrRepair
    } ghr_sel_e;

    function automatic ctr_t ctr_max(int unsigned ctr_bits);
        return ctr_t'((1 << ctr_bits) - 1);
    endfunction

    // Weakly not-taken: 2^(CTR_BITS-1)-1.
    function automatic ctr_t ctr_init(int unsigned ctr_bits);
        return ctr_t'((1 << (ctr_bits - 1)) - 1);
    endfunction

    function automatic ctr_t sat_inc(ctr_t v, int unsigned ctr_bits);
        return (v >= ctr_max(ctr_bits)) ? v : v + 1'b1;
    endfunction

    function automatic ctr_t sat_dec(ctr_t v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    // pc[IDX_BITS+1:2] XOR zero-extended history; result fits in the low idx_bits.
    function automatic logic [31:0] idx(logic [31:0] pc, logic [31:0] h,
                                        int unsigned idx_bits, int unsigned ghr_bits);
        logic [31:0] pc_mask;
        logic [31:0] h_mask;
        pc_mask = (32'd1 << idx_bits) - 32'd1;
        h_mask  = (32'd1 << ghr_bits) - 32'd1;
        return ((pc >> 2) & pc_mask) ^ (h & h_mask & pc_mask);
    endfunction

endpackage

// File: rtl/branch_gshare_pred_if.sv
// Predict / update / status bundle of the gshare predictor.
// master: fetch + resolve side (drives requests, observes prediction and stats).
// slave:  the predictor.
interface branch_gshare_pred_if #(
    parameter int unsigned GHR_BITS  = 8,
    parameter int unsigned STAT_BITS = 32
);
    logic                 pred_val;
    logic [31:0]          pred_pc;
    logic                 pred_taken;
    logic [GHR_BITS-1:0]  pred_ghr;
    logic                 upd_val;
    logic [31:0]          upd_pc;
    logic [GHR_BITS-1:0]  upd_ghr;
    logic                 upd_taken;
    logic                 upd_mispred;
    logic [GHR_BITS-1:0]  ghr_out;
    logic [STAT_BITS-1:0] stat_resolved;
    logic [STAT_BITS-1:0] stat_mispred;

    modport master (
        output pred_val, pred_pc, upd_val, upd_pc, upd_ghr, upd_taken, upd_mispred,
        input  pred_taken, pred_ghr, ghr_out, stat_resolved, stat_mispred
    );

    modport slave (
        input  pred_val, pred_pc, upd_val, upd_pc, upd_ghr, upd_taken, upd_mispred,
        output pred_taken, pred_ghr, ghr_out, stat_resolved, stat_mispred
    );
endinterface

// File: rtl/branch_sat_ctr_table.sv
// Pattern history table of saturating counters.
// Ports: clk, reset (sync, active-high, re-initialises every entry in one cycle),
//        rd_idx/rd_ctr (combinational read), wr_en/wr_idx/wr_taken (read-modify-write
//        saturating increment or decrement on the clock edge).
// A read of the entry being written in the same cycle returns the old value.
module branch_sat_ctr_table
    import branch_pred_pkg::*;
#(
    parameter int unsigned PHT_SIZE = 2048,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned IDX_BITS = $clog2(PHT_SIZE)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(ctr_init(CTR_BITS));

    logic [CTR_BITS-1:0] mem_q [PHT_SIZE];
    logic [CTR_BITS-1:0] wr_nxt;

    assign rd_ctr = mem_q[rd_idx];

    always_comb begin
        wr_nxt = mem_q[wr_idx];
        if (wr_taken) begin
            wr_nxt = CTR_BITS'(sat_inc(ctr_t'(mem_q[wr_idx]), CTR_BITS));
        end else begin
            wr_nxt = CTR_BITS'(sat_dec(ctr_t'(mem_q[wr_idx])));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(PHT_SIZE); i++) begin
                mem_q[i] <= CtrInit;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_nxt;
        end
    end
endmodule

// File: rtl/branch_gshare_pred.sv
// Gshare branch predictor: PHT indexed by PC XOR speculative global history.
// Ports: clk, reset (sync, active-high), bus (slave side of branch_gshare_pred_if):
//   pred_* - combinational prediction for the fetch PC plus the GHR snapshot used,
//   upd_*  - resolved branch training and mispredict GHR repair,
//   ghr_out, stat_resolved, stat_mispred - current GHR and saturating statistics.
module branch_gshare_pred
    import branch_pred_pkg::*;
#(
    parameter int unsigned PHT_SIZE  = 2048,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned GHR_BITS  = 8,
    parameter int unsigned STAT_BITS = 32
) (
    input logic                clk,
    input logic                reset,
    branch_gshare_pred_if.slave bus
);
    localparam int unsigned IDX_BITS = $clog2(PHT_SIZE);

    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [STAT_BITS-1:0] res_q, mis_q;
    logic [IDX_BITS-1:0]  rd_idx, wr_idx;
    logic [CTR_BITS-1:0]  rd_ctr;
    ghr_sel_e             ghr_sel;

    assign rd_idx = IDX_BITS'(idx(bus.pred_pc, 32'(ghr_q), IDX_BITS, GHR_BITS));
    assign wr_idx = IDX_BITS'(idx(bus.upd_pc, 32'(bus.upd_ghr), IDX_BITS, GHR_BITS));

    branch_sat_ctr_table #(
        .PHT_SIZE (PHT_SIZE),
        .CTR_BITS (CTR_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (rd_idx),
        .rd_ctr   (rd_ctr),
        .wr_en    (bus.upd_val),
        .wr_idx   (wr_idx),
        .wr_taken (bus.upd_taken)
    );

    assign bus.pred_taken    = rd_ctr[CTR_BITS-1];
    assign bus.pred_ghr      = ghr_q;
    assign bus.ghr_out       = ghr_q;
    assign bus.stat_resolved = res_q;
    assign bus.stat_mispred  = mis_q;

    // Mispredict repair takes precedence over a same-cycle speculative shift.
    always_comb begin
        ghr_sel = GhrHold;
        if (bus.upd_val && bus.upd_mispred) begin
            ghr_sel = GhrRepair;
        end else if (bus.pred_val) begin
            ghr_sel = GhrShift;
        end
    end

    // The truncating cast drops the oldest bit, so GHR_BITS == 1 keeps only the newest.
    always_comb begin
        ghr_d = ghr_q;
        unique case (ghr_sel)
            GhrRepair: ghr_d = GHR_BITS'({bus.upd_ghr, bus.upd_taken});
            GhrShift:  ghr_d = GHR_BITS'({ghr_q, bus.pred_taken});
            default:   ghr_d = ghr_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q <= '0;
            res_q <= '0;
            mis_q <= '0;
        end else begin
            ghr_q <= ghr_d;
            if (bus.upd_val && (res_q != '1)) begin
                res_q <= res_q + 1'b1;
            end
            if (bus.upd_val && bus.upd_mispred && (mis_q != '1)) begin
                mis_q <= mis_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_gshare_pred.sv
// Bench for branch_gshare_pred: directed scenarios followed by random traffic, all
// checked against a plain-array model of the predictor.
module tb_branch_gshare_pred;
    localparam int unsigned PHT   = 2048;
    localparam int unsigned CTRB  = 2;
    localparam int unsigned GHRB  = 8;
    localparam int unsigned STATB = 4;
    localparam int MAXC = (1 << CTRB) - 1;
    localparam int MAXS = (1 << STATB) - 1;
    localparam int MAXH = (1 << GHRB) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_gshare_pred_if #(.GHR_BITS(GHRB), .STAT_BITS(STATB)) bus ();

    branch_gshare_pred #(
        .PHT_SIZE  (PHT),
        .CTR_BITS  (CTRB),
        .GHR_BITS  (GHRB),
        .STAT_BITS (STATB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int pht [PHT];
    int m_ghr = 0;
    int m_res = 0;
    int m_mis = 0;
    bit m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc, input int h);
        int unsigned v;
        v = ((pc >> 2) ^ (h & MAXH)) % PHT;
        return int'(v);
    endfunction

    task automatic drive(input bit pv, input logic [31:0] ppc, input bit uv,
                         input logic [31:0] upc, input int ughr, input bit ut,
                         input bit um, input bit rst);
        bus.pred_val    = pv;
        bus.pred_pc     = ppc;
        bus.upd_val     = uv;
        bus.upd_pc      = upc;
        bus.upd_ghr     = GHRB'(ughr);
        bus.upd_taken   = ut;
        bus.upd_mispred = um;
        reset           = rst;
    endtask

    // Compare against the model, clock once, then advance the model.
    task automatic cycle();
        bit p;
        int k;
        #1;
        p = (pht[m_idx(bus.pred_pc, m_ghr)] > MAXC / 2);
        if (m_valid) begin
            check("pred_taken", 32'(bus.pred_taken), 32'(p));
            check("pred_ghr", 32'(bus.pred_ghr), 32'(m_ghr));
            check("ghr_out", 32'(bus.ghr_out), 32'(m_ghr));
            check("stat_resolved", 32'(bus.stat_resolved), 32'(m_res));
            check("stat_mispred", 32'(bus.stat_mispred), 32'(m_mis));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < int'(PHT); i++) pht[i] = (1 << (CTRB - 1)) - 1;
            m_ghr = 0;
            m_res = 0;
            m_mis = 0;
            m_valid = 1'b1;
        end else begin
            if (bus.upd_val) begin
                k = m_idx(bus.upd_pc, int'(bus.upd_ghr));
                if (bus.upd_taken) pht[k] = (pht[k] < MAXC) ? pht[k] + 1 : MAXC;
                else               pht[k] = (pht[k] > 0) ? pht[k] - 1 : 0;
                if (m_res < MAXS) m_res++;
                if (bus.upd_mispred && m_mis < MAXS) m_mis++;
            end
            if (bus.upd_val && bus.upd_mispred)
                m_ghr = ((int'(bus.upd_ghr) << 1) | int'(bus.upd_taken)) & MAXH;
            else if (bus.pred_val)
                m_ghr = ((m_ghr << 1) | int'(p)) & MAXH;
        end
        @(negedge clk);
    endtask

    task automatic idle_peek(input logic [31:0] ppc);
        drive(0, ppc, 0, 0, 0, 0, 0, 0);
        #1;
    endtask

    initial begin
        logic [31:0] pc, upc;
        int ughr;

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        cycle();

        // Post-reset state
        drive(1, 'h100, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_pred_taken", 32'(bus.pred_taken), 0);
        check("rst_pred_ghr", 32'(bus.pred_ghr), 0);
        check("rst_stat_res", 32'(bus.stat_resolved), 0);
        check("rst_stat_mis", 32'(bus.stat_mispred), 0);
        cycle();

        // Train 01 -> 10 -> 11
        repeat (2) begin drive(0, 'h100, 1, 'h100, 0, 1, 0, 0); cycle(); end
        idle_peek('h100);
        check("train_taken", 32'(bus.pred_taken), 1);
        cycle();
        drive(0, 'h100, 1, 'h100, 0, 1, 0, 0); cycle();   // stays 11
        drive(0, 'h100, 1, 'h100, 0, 0, 0, 0); cycle();   // 10
        idle_peek('h100);
        check("sat_hi_hold", 32'(bus.pred_taken), 1);
        cycle();
        repeat (3) begin drive(0, 'h100, 1, 'h100, 0, 0, 0, 0); cycle(); end  // 00, held
        drive(0, 'h100, 1, 'h100, 0, 1, 0, 0); cycle();   // 01
        idle_peek('h100);
        check("sat_lo_hold", 32'(bus.pred_taken), 0);
        check("stat_res_8", 32'(bus.stat_resolved), 8);
        cycle();

        // Not-taken predictions keep the GHR at zero; repair beats same-cycle shift
        repeat (10) begin drive(1, 'h100, 0, 0, 0, 0, 0, 0); cycle(); end
        idle_peek('h100);
        check("ghr_nt_10", 32'(bus.ghr_out), 0);
        cycle();
        drive(1, 'h100, 1, 'h200, 'h05, 1, 1, 0); cycle();
        idle_peek('h100);
        check("ghr_repair", 32'(bus.ghr_out), 'h0B);
        cycle();

        // Aliasing: pc 0x104 under ghr 0x01 shares the entry of pc 0x100 under ghr 0
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        drive(0, 'h800, 1, 'h800, 0, 1, 1, 0); cycle();
        repeat (2) begin drive(0, 'h100, 1, 'h100, 0, 1, 0, 0); cycle(); end
        idle_peek('h104);
        check("alias_ghr", 32'(bus.pred_ghr), 1);
        check("alias_taken", 32'(bus.pred_taken), 1);
        cycle();

        // Same-cycle predict and update to one entry: read-before-write
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        drive(1, 'h100, 1, 'h100, 0, 1, 0, 0);
        #1;
        check("rbw_old", 32'(bus.pred_taken), 0);
        cycle();
        idle_peek('h100);
        check("rbw_new", 32'(bus.pred_taken), 1);
        cycle();

        // Statistics saturation, then mid-stream reset discards the update
        drive(0, 0, 0, 0, 0, 0, 0, 1); cycle();
        repeat (20) begin drive(0, 'h100, 1, 'h100, 0, 1, 1, 0); cycle(); end
        idle_peek('h100);
        check("stat_res_sat", 32'(bus.stat_resolved), 15);
        check("stat_mis_sat", 32'(bus.stat_mispred), 15);
        cycle();
        drive(0, 'h100, 1, 'h100, 0, 0, 1, 1); cycle();
        idle_peek('h100);
        check("rst2_stat_res", 32'(bus.stat_resolved), 0);
        check("rst2_stat_mis", 32'(bus.stat_mispred), 0);
        check("rst2_ghr", 32'(bus.ghr_out), 0);
        check("rst2_pred", 32'(bus.pred_taken), 0);
        cycle();

        // Random traffic on a small set of PCs so entries collide and saturate
        for (int n = 0; n < 600; n++) begin
            pc  = ($urandom_range(0, 3) == 0) ? $urandom
                : (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 12);
            upc = ($urandom_range(0, 3) == 0) ? $urandom
                : (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 12);
            ughr = ($urandom_range(0, 1) == 0) ? m_ghr : int'($urandom_range(0, MAXH));
            drive(bit'($urandom_range(0, 1)), pc, bit'($urandom_range(0, 1)), upc, ughr,
                  bit'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
